// File: rtl/ps2_lock_led_if.sv
// Signal bundle between the lock/LED controller and the PS/2 receive path,
// keycode recognizer and host transmitter.
interface ps2_lock_led_if;
  logic [7:0] keycode;
  logic       ext;
  logic       make;
  logic       keycode_ready;
  logic       ps2_key_en;
  logic [7:0] ps2_key_data;
  logic       key_en_out;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       tx_error;
  logic [2:0] leds;
  logic       busy;
  logic       led_error;

  modport master (
    input  keycode, ext, make, keycode_ready, ps2_key_en, ps2_key_data,
           tx_done, tx_error,
    output key_en_out, tx_data, tx_start, leds, busy, led_error
  );

  modport slave (
    output keycode, ext, make, keycode_ready, ps2_key_en, ps2_key_data,
           tx_done, tx_error,
    input  key_en_out, tx_data, tx_start, leds, busy, led_error
  );
endinterface

// File: rtl/ps2_lock_led_controller.sv
// Caps/Num/Scroll lock tracking and keyboard Set-LED (0xED) command sequencer.
// Optional PS2_LED_INIT_SYNC_EN: reset to Num Lock on and push it to the keyboard.
module ps2_lock_led_controller #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  ps2_lock_led_if.master bus
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Bit order matches leds: [2]=caps 0x58, [1]=num 0x77, [0]=scroll 0x7E.
  localparam logic [23:0] LOCK_CODES = {8'h58, 8'h77, 8'h7E};
  localparam logic [7:0]  CMD_SET_LED = 8'hED;
  localparam logic [7:0]  RSP_ACK     = 8'hFA;
  localparam logic [7:0]  RSP_RESEND  = 8'hFE;

  typedef enum logic [2:0] {
    IDLE, TX_ED, WAIT_TX_ED, ACK_ED, TX_LED, WAIT_TX_LED, ACK_LED
  } state_e;

  state_e          state_q;
  logic [2:0]      leds_q, held_q;
  logic [2:0]      leds_d, held_d, lock_hit;
  logic            dirty_q, set_dirty;
  logic [RW-1:0]   retry_q;
  logic [TW-1:0]   timer_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            led_error_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lock
    assign lock_hit[gi] = bus.keycode_ready & ~bus.ext &
                          (bus.keycode == LOCK_CODES[gi*8 +: 8]);
    // Only the first make after a break toggles; typematic repeats are absorbed.
    assign leds_d[gi]   = leds_q[gi] ^ (lock_hit[gi] & bus.make & ~held_q[gi]);
    assign held_d[gi]   = lock_hit[gi] ? bus.make : held_q[gi];
  end

  assign set_dirty = (|(lock_hit & ~held_q)) & bus.make;

  logic in_wait, in_ack, ed_phase, timer_exp, rsp_ack, rsp_resend, fail;

  assign in_wait    = (state_q == WAIT_TX_ED) || (state_q == WAIT_TX_LED);
  assign in_ack     = (state_q == ACK_ED)     || (state_q == ACK_LED);
  assign ed_phase   = (state_q == WAIT_TX_ED) || (state_q == ACK_ED);
  assign timer_exp  = (timer_q == TIMER_LAST);
  assign rsp_ack    = bus.ps2_key_en && (bus.ps2_key_data == RSP_ACK);
  assign rsp_resend = bus.ps2_key_en && (bus.ps2_key_data == RSP_RESEND);
  // A completion arriving on the expiry cycle wins over the timeout.
  assign fail = (in_wait && !bus.tx_done && (bus.tx_error || timer_exp)) ||
                (in_ack  && !rsp_ack     && (rsp_resend   || timer_exp));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
`ifdef PS2_LED_INIT_SYNC_EN
      leds_q      <= 3'b010;
      dirty_q     <= 1'b1;
`else
      leds_q      <= 3'b000;
      dirty_q     <= 1'b0;
`endif
      held_q      <= 3'b000;
      retry_q     <= '0;
      timer_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      led_error_q <= 1'b0;
    end else begin
      leds_q     <= leds_d;
      held_q     <= held_d;
      tx_start_q <= 1'b0;
      // A toggle in the same cycle IDLE consumes dirty re-arms it for another pass.
      dirty_q    <= set_dirty | (dirty_q & (state_q != IDLE));

      if (fail) begin
        timer_q <= '0;
        if (retry_q < RETRY_MAX) begin
          retry_q <= retry_q + 1'b1;
          state_q <= ed_phase ? TX_ED : TX_LED;
        end else begin
          led_error_q <= 1'b1;
          state_q     <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (dirty_q) begin
              retry_q <= '0;
              state_q <= TX_ED;
            end
          end
          TX_ED: begin
            tx_start_q <= 1'b1;
            tx_data_q  <= CMD_SET_LED;
            timer_q    <= '0;
            state_q    <= WAIT_TX_ED;
          end
          TX_LED: begin
            tx_start_q <= 1'b1;
            tx_data_q  <= {5'b00000, leds_q};
            timer_q    <= '0;
            state_q    <= WAIT_TX_LED;
          end
          WAIT_TX_ED, WAIT_TX_LED: begin
            if (bus.tx_done) begin
              timer_q <= '0;
              state_q <= (state_q == WAIT_TX_ED) ? ACK_ED : ACK_LED;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ACK_ED: begin
            if (rsp_ack) begin
              retry_q <= '0;
              state_q <= TX_LED;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ACK_LED: begin
            if (rsp_ack) begin
              led_error_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Keyboard responses are hidden from the recognizer while a command is in flight.
  assign bus.key_en_out = bus.ps2_key_en & ~(in_wait | in_ack);
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.leds       = leds_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.led_error  = led_error_q;

endmodule

// File: tb/tb_ps2_lock_led_controller.sv
// Directed bench: lock toggling, ED/LED sequencing, resend, timeout, masking, reset.
module tb_ps2_lock_led_controller;
  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] tx_q[$];
  logic ken;

  ps2_lock_led_if bus();

  ps2_lock_led_controller #(.TIMEOUT_CYCLES(100), .MAX_RETRY(3)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.tx_start) tx_q.push_back(bus.tx_data);

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic key(input logic [7:0] code, input logic e, input logic m);
    bus.keycode = code; bus.ext = e; bus.make = m; bus.keycode_ready = 1'b1;
    @(negedge clk);
    bus.keycode_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic k);
    bus.ps2_key_data = b; bus.ps2_key_en = 1'b1;
    #1 k = bus.key_en_out;
    @(negedge clk);
    bus.ps2_key_en = 1'b0;
  endtask

  task automatic done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (tx_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(tx_q.size() != 0), 32'd1);
    if (tx_q.size() != 0) check({tag, "_byte"}, 32'(tx_q.pop_front()), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // One full happy-path sequence for a given LED byte.
  task automatic good_seq(input string tag, input logic [7:0] led_byte);
    wait_tx({tag, "_ed"}, 8'hED);
    done();
    send_byte(8'hFA, ken);
    wait_tx({tag, "_led"}, led_byte);
    done();
    send_byte(8'hFA, ken);
    wait_idle(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.keycode = 8'h00; bus.ext = 1'b0; bus.make = 1'b0; bus.keycode_ready = 1'b0;
    bus.ps2_key_en = 1'b0; bus.ps2_key_data = 8'h00;
    bus.tx_done = 1'b0; bus.tx_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(bus.leds), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.led_error), 32'd0);
    check("rst_txs", 32'(bus.tx_start), 32'd0);
    check("rst_txd", 32'(bus.tx_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    send_byte(8'h12, ken);
    check("idle_key_en", 32'(ken), 32'd1);
    repeat (5) @(negedge clk);
    check("idle_no_tx", 32'(tx_q.size()), 32'd0);

    // Caps press
    key(8'h58, 1'b0, 1'b1);
    check("caps_leds", 32'(bus.leds), 32'h4);
    wait_tx("caps_ed", 8'hED);
    check("caps_busy", 32'(bus.busy), 32'd1);
    done();
    send_byte(8'hFA, ken);
    check("mask_ack_ed", 32'(ken), 32'd0);
    wait_tx("caps_led", 8'h04);
    done();
    send_byte(8'hFA, ken);
    wait_idle("caps");
    check("caps_err", 32'(bus.led_error), 32'd0);
    key(8'h58, 1'b0, 1'b0);

    // Typematic: three makes, one toggle
    key(8'h77, 1'b0, 1'b1);
    key(8'h77, 1'b0, 1'b1);
    key(8'h77, 1'b0, 1'b1);
    check("typ_leds1", 32'(bus.leds), 32'h6);
    good_seq("typ1", 8'h06);
    check("typ_no_extra", 32'(tx_q.size()), 32'd0);
    key(8'h77, 1'b0, 1'b0);
    key(8'h77, 1'b0, 1'b1);
    check("typ_leds2", 32'(bus.leds), 32'h4);
    good_seq("typ2", 8'h04);
    key(8'h77, 1'b0, 1'b0);

    // Resend twice on ED
    key(8'h7E, 1'b0, 1'b1);
    check("rs_leds", 32'(bus.leds), 32'h5);
    for (int i = 0; i < 2; i++) begin
      wait_tx("rs_ed", 8'hED);
      done();
      send_byte(8'hFE, ken);
    end
    good_seq("rs", 8'h05);
    check("rs_err", 32'(bus.led_error), 32'd0);
    key(8'h7E, 1'b0, 1'b0);

    // Timeout on LED byte, four attempts then abort
    key(8'h58, 1'b0, 1'b1);
    key(8'h58, 1'b0, 1'b0);
    wait_tx("to_ed", 8'hED);
    done();
    send_byte(8'hFA, ken);
    for (int i = 0; i < 4; i++) begin
      wait_tx("to_led", 8'h01);
      done();
    end
    wait_idle("to");
    check("to_err", 32'(bus.led_error), 32'd1);
    repeat (20) @(negedge clk);
    check("to_no_retx", 32'(tx_q.size()), 32'd0);
    key(8'h77, 1'b0, 1'b1);
    key(8'h77, 1'b0, 1'b0);
    good_seq("to_rec", 8'h03);
    check("to_err_clr", 32'(bus.led_error), 32'd0);

    // Extended 7E is not scroll lock
    key(8'h7E, 1'b1, 1'b1);
    key(8'h7E, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("ext_leds", 32'(bus.leds), 32'h3);
    check("ext_no_tx", 32'(tx_q.size()), 32'd0);

    // Toggle landing in ACK_ED: new value sent, then a repeat sequence
    key(8'h7E, 1'b0, 1'b1);
    key(8'h7E, 1'b0, 1'b0);
    check("mid_leds1", 32'(bus.leds), 32'h2);
    wait_tx("mid_ed", 8'hED);
    done();
    key(8'h7E, 1'b0, 1'b1);
    key(8'h7E, 1'b0, 1'b0);
    check("mid_leds2", 32'(bus.leds), 32'h3);
    send_byte(8'hFA, ken);
    wait_tx("mid_led", 8'h03);
    done();
    send_byte(8'hFA, ken);
    good_seq("mid_rep", 8'h03);

    // Reset while waiting on the LED byte
    key(8'h58, 1'b0, 1'b1);
    key(8'h58, 1'b0, 1'b0);
    wait_tx("rr_ed", 8'hED);
    done();
    send_byte(8'hFA, ken);
    wait_tx("rr_led", 8'h07);
    reset_n = 1'b0;
    @(negedge clk);
    check("rr_leds", 32'(bus.leds), 32'd0);
    check("rr_busy", 32'(bus.busy), 32'd0);
    check("rr_txs", 32'(bus.tx_start), 32'd0);
    check("rr_txd", 32'(bus.tx_data), 32'd0);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    check("rr_no_tx", 32'(tx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
